// File: rtl/regfile_wr_arbiter_if.sv
// Bundle between the three write requesters and the register-file write-port arbiter.
// The requester side drives requests, locks, addresses and data; the arbiter side drives grants and the write port.
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [2:0]        req;
    logic [2:0]        lock;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [DATA_W-1:0] data0, data1, data2;
    logic [2:0]        ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic [1:0]        owner;
    logic              wr_err;

    modport master (
        output req, lock, addr0, addr1, addr2, data0, data1, data2,
        input  ack, wr_en, wr_addr, wr_data, busy, owner, wr_err
    );

    modport slave (
        input  req, lock, addr0, addr1, addr2, data0, data1, data2,
        output ack, wr_en, wr_addr, wr_data, busy, owner, wr_err
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port among ALU (0), load (1) and I/O (2),
// with locked bursts of up to MAX_BURST writes and optional suppression of writes to R0.
module regfile_wr_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int MAX_BURST  = 4,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  bus
);
    typedef enum logic {ARB, BURST} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [3:0]        burst_cnt;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              busy_q;
    logic [1:0]        owner_q;
    logic              wr_err_q;

    logic [1:0]        gnt_idx;
    logic              gnt_vld;
    logic [1:0]        p;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic [3:0]        cnt_inc;
    state_t            state_nxt;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_idx = 2'd0;
        gnt_vld = 1'b0;
        p       = nxt(rr_ptr);
        if (!reset) begin
            gnt_vld = 1'b0;
        end else if (state == BURST) begin
            gnt_idx = rr_ptr;
            gnt_vld = bus.req[rr_ptr];
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!gnt_vld && bus.req[p]) begin
                    gnt_idx = p;
                    gnt_vld = 1'b1;
                end
                p = nxt(p);
            end
        end
    end

    always_comb begin
        gnt_addr = bus.addr2;
        gnt_data = bus.data2;
        case (gnt_idx)
            2'd0: begin gnt_addr = bus.addr0; gnt_data = bus.data0; end
            2'd1: begin gnt_addr = bus.addr1; gnt_data = bus.data1; end
            default: ;
        endcase
    end

    // Burst termination: the owner drops req, drops lock, or the count reaches the limit.
    always_comb begin
        cnt_inc   = burst_cnt + 4'd1;
        state_nxt = state;
        if (state == ARB) begin
            if (gnt_vld && bus.lock[gnt_idx]) state_nxt = BURST;
        end else if (!gnt_vld || !bus.lock[rr_ptr] || cnt_inc == MAX_CNT) begin
            state_nxt = ARB;
        end
    end

    assign bus.ack = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            rr_ptr    <= 2'd2;
            burst_cnt <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            owner_q   <= 2'd0;
            wr_err_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy_q  <= (state_nxt == BURST);
            wr_en_q  <= 1'b0;
            wr_err_q <= 1'b0;
            if (state_nxt == BURST) begin
                burst_cnt <= (state == ARB) ? 4'd1 : cnt_inc;
            end else begin
                burst_cnt <= 4'd0;
            end
            if (gnt_vld) begin
                rr_ptr  <= gnt_idx;
                owner_q <= gnt_idx;
                if (PROTECT_R0 && gnt_addr == '0) begin
                    wr_err_q <= 1'b1;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= gnt_addr;
                    wr_data_q <= gnt_data;
                end
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
    assign bus.wr_err  = wr_err_q;
endmodule
